// File: rtl/gate_check_pkg.sv
// Shared types and reference truth tables for the gate sweep checker.
// Truth-table bit i is the expected gate output when the input vector equals i.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_e;

    localparam logic [3:0] NAND2_TT = 4'b0111;
    localparam logic [3:0] AND2_TT  = 4'b1000;
    localparam logic [3:0] OR2_TT   = 4'b1110;
    localparam logic [3:0] XOR2_TT  = 4'b0110;

endpackage

// File: rtl/gate_sweep_checker_vec_gen.sv
// Vector and settle counters for the sweep: holds the vector driven to the gate
// and tells the controller when that vector has settled and when it is the last one.
module sweep_vec_gen
    import gate_check_pkg::*;
#(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            advance_i,
    input  logic            count_i,
    output logic [N_IN-1:0] vec_o,
    output logic            settled_o,
    output logic            last_vec_o
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    logic [N_IN-1:0] vec_q, vec_d;
    logic [SW-1:0]   settleCnt_q, settleCnt_d;

    // Advancing to a new vector restarts the settle count so every vector
    // gets the same hold time before it is checked.
    always_comb begin
        vec_d       = vec_q;
        settleCnt_d = settleCnt_q;
        if (clear_i) begin
            vec_d       = '0;
            settleCnt_d = '0;
        end else if (advance_i) begin
            vec_d       = vec_q + 1'b1;
            settleCnt_d = '0;
        end else if (count_i) begin
            settleCnt_d = settleCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q       <= '0;
            settleCnt_q <= '0;
        end else begin
            vec_q       <= vec_d;
            settleCnt_q <= settleCnt_d;
        end
    end

    assign vec_o      = vec_q;
    assign settled_o  = (settleCnt_q == SETTLE_LAST);
    assign last_vec_o = &vec_q;

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweeper and scoreboard for a small combinational gate.
// Define STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module gate_sweep_checker
    import gate_check_pkg::*;
#(
    parameter int                   N_IN          = 2,
    parameter int                   SETTLE_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0] EXP_TT        = NAND2_TT,
    parameter int                   CNT_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [N_IN-1:0]  fail_vec,
    output logic             fail_valid
);

    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] errCount_q, errCount_d;
    logic             overflow_q, overflow_d;
    logic [N_IN-1:0]  failVec_q, failVec_d;
    logic             failValid_q, failValid_d;

    logic             vecClear, vecAdvance, settleCount;
    logic [N_IN-1:0]  vec;
    logic             settled, lastVec;
    logic             mismatch, stopNow;

    sweep_vec_gen #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_vec_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (vecClear),
        .advance_i  (vecAdvance),
        .count_i    (settleCount),
        .vec_o      (vec),
        .settled_o  (settled),
        .last_vec_o (lastVec)
    );

    // X or Z on the gate output must never be taken as a correct answer.
    assign mismatch = (dut_y !== EXP_TT[vec]);

`ifdef STOP_ON_FAIL_EN
    assign stopNow = mismatch;
`else
    assign stopNow = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        errCount_d  = errCount_q;
        overflow_d  = overflow_q;
        failVec_d   = failVec_q;
        failValid_d = failValid_q;
        vecClear    = 1'b0;
        vecAdvance  = 1'b0;
        settleCount = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SETTLE;
                    vecClear    = 1'b1;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    errCount_d  = '0;
                    overflow_d  = 1'b0;
                    failValid_d = 1'b0;
                end
            end
            SETTLE: begin
                if (settled) begin
                    state_d = CHECK;
                end else begin
                    settleCount = 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (errCount_q == ERR_MAX) begin
                        overflow_d = 1'b1;
                    end else begin
                        errCount_d = errCount_q + 1'b1;
                    end
                    if (!failValid_q) begin
                        failVec_d   = vec;
                        failValid_d = 1'b1;
                    end
                end
                // The verdict is registered on the same edge that enters DONE,
                // so it includes the mismatch of the final vector.
                if (lastVec || stopNow) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (errCount_d == '0) && !overflow_d;
                end else begin
                    state_d    = SETTLE;
                    vecAdvance = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            errCount_q  <= '0;
            overflow_q  <= 1'b0;
            failVec_q   <= '0;
            failValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            errCount_q  <= errCount_d;
            overflow_q  <= overflow_d;
            failVec_q   <= failVec_d;
            failValid_q <= failValid_d;
        end
    end

    assign dut_in     = vec;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = errCount_q;
    assign fail_vec   = failVec_q;
    assign fail_valid = failValid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three configurations checked against a truth-table model.
// Follows STOP_ON_FAIL_EN when it is defined for the build.
module tb_gate_sweep_checker;

`ifdef STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start2 = 1'b0, start3 = 1'b0, start8 = 1'b0;
    logic [3:0] tt2 = 4'b0111, tt3 = 4'b0111;
    logic [7:0] tt8 = 8'h7F;
    logic       xOn = 1'b0;
    logic [1:0] xVec = 2'd0;

    logic [1:0] in2, in3, fv2, fv3;
    logic [2:0] in8, fv8, err2, err3;
    logic [1:0] err8;
    logic       y2, y3, y8;
    logic       busy2, busy3, busy8, done2, done3, done8;
    logic       pass2, pass3, pass8, fval2, fval3, fval8;

    int checks = 0;
    int errors = 0;
    int sel = 2;

    logic [7:0] obsIn, obsErr, obsFailVec;
    logic       obsBusy, obsDone, obsPass, obsFv;

    always #5 clk = ~clk;

    // Ideal or faulty gate models, chosen by truth table; dut3 can emit X.
    assign y2 = tt2[in2];
    assign y3 = (xOn && in3 == xVec) ? 1'bx : tt3[in3];
    assign y8 = tt8[in8];

    gate_sweep_checker dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_in(in2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_vec(fv2), .fail_valid(fval2)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .dut_in(in3), .dut_y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_vec(fv3), .fail_valid(fval3)
    );

    gate_sweep_checker #(.N_IN(3), .CNT_W(2), .EXP_TT(8'h7F)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dut_in(in8), .dut_y(y8),
        .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
        .fail_vec(fv8), .fail_valid(fval8)
    );

    always_comb begin
        obsIn = 8'(in2); obsErr = 8'(err2); obsFailVec = 8'(fv2);
        obsBusy = busy2; obsDone = done2; obsPass = pass2; obsFv = fval2;
        if (sel == 3) begin
            obsIn = 8'(in3); obsErr = 8'(err3); obsFailVec = 8'(fv3);
            obsBusy = busy3; obsDone = done3; obsPass = pass3; obsFv = fval3;
        end else if (sel == 8) begin
            obsIn = 8'(in8); obsErr = 8'(err8); obsFailVec = 8'(fv8);
            obsBusy = busy8; obsDone = done8; obsPass = pass8; obsFv = fval8;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse accepted at the next rising edge (edge 0).
    task automatic applyStimulus(input int which);
        @(negedge clk);
        if (which == 2) start2 = 1'b1;
        else if (which == 3) start3 = 1'b1;
        else start8 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0; start3 = 1'b0; start8 = 1'b0;
    endtask

    // Runs one sweep and compares it with the truth-table model.
    task automatic runSweep(input int which, input logic [7:0] tt, input int xv, input string tag);
        int n, settle, cntw, nv, errs, first, last, expDone, expErr, gotDone, expIn;
        logic [7:0] expTt;
        n      = (which == 8) ? 3 : 2;
        settle = (which == 3) ? 3 : 1;
        cntw   = (which == 8) ? 2 : 3;
        expTt  = (which == 8) ? 8'h7F : 8'h07;
        nv     = 1 << n;
        errs   = 0;
        first  = -1;
        last   = nv - 1;
        for (int v = 0; v < nv; v++) begin
            if (v == xv || tt[v] != expTt[v]) begin
                errs++;
                if (first < 0) first = v;
                if (STOP) begin
                    last = v;
                    break;
                end
            end
        end
        expDone = (last + 1) * (settle + 1) + 1;
        expErr  = (errs > (1 << cntw) - 1) ? (1 << cntw) - 1 : errs;

        sel = which;
        if (which == 2) tt2 = tt[3:0];
        else if (which == 3) tt3 = tt[3:0];
        else tt8 = tt;
        xOn  = (xv >= 0);
        xVec = 2'(xv);
        applyStimulus(which);

        gotDone = -1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (c <= expDone) begin
                expIn = (c - 1) / (settle + 1);
                if (expIn > last) expIn = last;
                checkOutput({tag, ".dut_in"}, 32'(obsIn), 32'(expIn));
                checkOutput({tag, ".busy"}, 32'(obsBusy), 32'(c < expDone));
            end
            if (obsDone === 1'b1) begin
                gotDone = c;
                break;
            end
        end
        checkOutput({tag, ".doneCycle"}, 32'(gotDone), 32'(expDone));
        checkOutput({tag, ".pass"}, 32'(obsPass), 32'(errs == 0));
        checkOutput({tag, ".errCount"}, 32'(obsErr), 32'(expErr));
        checkOutput({tag, ".failValid"}, 32'(obsFv), 32'(errs > 0));
        if (errs > 0) checkOutput({tag, ".failVec"}, 32'(obsFailVec), 32'(first));
        @(negedge clk);
        checkOutput({tag, ".donePulse"}, 32'({obsDone, obsBusy}), 32'(0));
        checkOutput({tag, ".inHeld"}, 32'(obsIn), 32'(last));
        xOn = 1'b0;
    endtask

    initial begin
        int doneCount, firstDone, secondDone;
        logic [7:0] rtt;

        // Reset values while rst_n is held low.
        #1;
        checkOutput("reset2", {in2, busy2, done2, pass2, err2, fv2, fval2}, 32'(0));
        checkOutput("reset8", {in8, busy8, done8, pass8, err8, fv8, fval8}, 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        runSweep(2, 8'h07, -1, "nand");
        runSweep(2, 8'h0F, -1, "stuck1");
        runSweep(2, 8'h00, -1, "stuck0");
        for (int i = 0; i < 6; i++) begin
            rtt = 8'($urandom_range(0, 15));
            runSweep(2, rtt, -1, "rand2");
        end
        runSweep(3, 8'h07, 1, "xSettle3");
        runSweep(8, 8'h7F, -1, "nand3");
        runSweep(8, 8'h00, -1, "sat8");
        for (int i = 0; i < 4; i++) begin
            rtt = 8'($urandom_range(0, 255));
            runSweep(8, rtt, -1, "rand8");
        end

        // Reset in the middle of a sweep, while vector 2 is driven.
        sel = 2;
        tt2 = 4'b0111;
        applyStimulus(2);
        for (int c = 0; c < 20 && obsIn != 8'd2; c++) @(negedge clk);
        checkOutput("midReset.reach", 32'(obsIn), 32'(2));
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.outs", {in2, busy2, done2, pass2, err2, fv2, fval2}, 32'(0));
        doneCount = 0;
        repeat (4) begin
            @(negedge clk);
            if (done2) doneCount++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done2) doneCount++;
        end
        checkOutput("midReset.noDone", 32'(doneCount), 32'(0));
        runSweep(2, 8'h07, -1, "afterReset");

        // Start held high for 20 cycles: two sweeps, done in cycles 9 and 19.
        doneCount = 0;
        firstDone = -1;
        secondDone = -1;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (done2) begin
                doneCount++;
                if (firstDone < 0) firstDone = c;
                else if (secondDone < 0) secondDone = c;
            end
            if (c == 20) start2 = 1'b0;
        end
        checkOutput("held.count", 32'(doneCount), 32'(2));
        checkOutput("held.first", 32'(firstDone), 32'(9));
        checkOutput("held.second", 32'(secondDone), 32'(19));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
